// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: wrap or saturate, clamped parallel load, boundary flags; optional prescaler via COUNTER_PRESCALE_EN.
// Latency: counter_out/bound_hit register one cycle after inputs are sampled; at_max/at_min decode counter_out combinationally.
// Backpressure: none, every input is accepted each cycle with priority rst > load > enable.
module updown_counter_param #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned STEP     = 1,
  parameter int              SATURATE = 0,
  parameter int              PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             direction,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter_out,
  output logic             bound_hit,
  output logic             at_max,
  output logic             at_min
);

  if (WIDTH < 2 || WIDTH > 32 || MAX_VAL < 1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1) ||
      STEP < 1 || STEP > MAX_VAL || PRESCALE < 2 || PRESCALE > 256) begin : g_bad_param
    $error("updown_counter_param: illegal parameter combination");
  end

  localparam logic [WIDTH-1:0] MAX_W    = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] STEP_W   = STEP[WIDTH-1:0];
  // (MAX_VAL+1)-STEP: subtracting it wraps upward overflow, adding it wraps downward underflow.
  localparam logic [WIDTH-1:0] WRAP_ADJ = WIDTH'(MAX_VAL + 64'd1 - STEP);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic [WIDTH:0]   up_sum;
  logic             tick;

`ifdef COUNTER_PRESCALE_EN
  localparam int             PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;

  always_comb begin
    ps_d = ps_q;
    tick = 1'b0;
    if (enable) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        tick = 1'b1;
      end else begin
        ps_d = ps_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  assign tick = enable;
`endif

  always_comb begin
    up_sum = {1'b0, cnt_q} + {1'b0, STEP_W};
    cnt_d  = cnt_q;
    hit_d  = 1'b0;
    if (load) begin
      cnt_d = (load_value > MAX_W) ? MAX_W : load_value;
    end else if (tick) begin
      if (direction) begin
        if (up_sum > {1'b0, MAX_W}) begin
          hit_d = 1'b1;
          cnt_d = (SATURATE != 0) ? MAX_W : cnt_q - WRAP_ADJ;
        end else begin
          cnt_d = up_sum[WIDTH-1:0];
        end
      end else begin
        if (cnt_q < STEP_W) begin
          hit_d = 1'b1;
          cnt_d = (SATURATE != 0) ? '0 : cnt_q + WRAP_ADJ;
        end else begin
          cnt_d = cnt_q - STEP_W;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

  assign counter_out = cnt_q;
  assign bound_hit   = hit_q;
  assign at_max      = (cnt_q == MAX_W);
  assign at_min      = (cnt_q == '0);

endmodule
